pc_gen: RTL and testbench

- Parametrised next-generation program counter and fetch-request generator for the RV32 core front end.
- Holds the current fetch PC and presents it to instruction memory over a valid/ready handshake.
- Advances by a fixed instruction step, or loads redirect, trap or halt/resume targets under a fixed priority.
- Counts accepted fetches, flags misaligned redirect targets, and sits between the hazard/branch/trap logic and the I-fetch port.

---
 rtl/pc_gen_pkg.sv | 11 +
 rtl/pc_gen.sv | 69 ++++++
 tb/tb_pc_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defaults and FSM encoding for the front-end PC generator.
package pc_gen_pkg;
    localparam int          XLEN_D       = 32;
    localparam logic [31:0] RESET_PC_D   = 32'h0000_0000;
    localparam int          STEP_D       = 4;
    localparam int          ALIGN_BITS_D = 2;
    localparam int          CNT_W_D      = 32;
    localparam logic [1:0]  BOOT   = 2'd0;
    localparam logic [1:0]  RUN    = 2'd1;
    localparam logic [1:0]  HALTED = 2'd2;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register, next-PC priority mux, run/halt FSM and accepted-fetch counter.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               XLEN       = XLEN_D,
    parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(RESET_PC_D),
    parameter int               STEP       = STEP_D,
    parameter int               ALIGN_BITS = ALIGN_BITS_D,
    parameter int               CNT_W      = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_pc,
    output logic [XLEN-1:0]  pc_plus_step,
    output logic             misalign,
    output logic [XLEN-1:0]  misalign_pc,
    output logic [CNT_W-1:0] fetch_count,
    output logic             halted
);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_d;
    logic            accept, redir_ok, redir_bad;

    assign fetch_valid  = (state_q == RUN) && !stall;
    assign accept       = fetch_valid && fetch_ready;
    assign pc_plus_step = fetch_pc + XLEN'(STEP);
    assign halted       = state_q == HALTED;
    // A trap supersedes any redirect, so a misaligned redirect under a trap is not reported.
    assign redir_ok     = redirect_valid && !trap_valid && ~|redirect_pc[ALIGN_BITS-1:0];
    assign redir_bad    = redirect_valid && !trap_valid && |redirect_pc[ALIGN_BITS-1:0];

    always_comb begin
        pc_d    = trap_valid ? (trap_pc & ALIGN_MASK) :
                  redir_ok   ? redirect_pc :
                  accept     ? pc_plus_step : fetch_pc;
        state_d = state_q == BOOT ? RUN :
                  state_q == RUN  ? ((halt_req && !trap_valid) ? HALTED : RUN) :
                  (resume && !halt_req) ? RUN : HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            fetch_pc    <= RESET_PC;
            misalign    <= 1'b0;
            misalign_pc <= '0;
            fetch_count <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc    <= pc_d;
            misalign    <= redir_bad;
            if (redir_bad)
                misalign_pc <= redirect_pc;
            if (accept)
                fetch_count <= fetch_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; per-cycle expected PC/count are queued then checked.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, trap_valid, halt_req, resume, fetch_ready;
    logic [31:0] redirect_pc, trap_pc;
    logic        fetch_valid, misalign, halted;
    logic [31:0] fetch_pc, pc_plus_step, misalign_pc, fetch_count;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    int n_assert = 0;
    int n_fail = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .halt_req(halt_req), .resume(resume),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .pc_plus_step(pc_plus_step),
        .misalign(misalign), .misalign_pc(misalign_pc),
        .fetch_count(fetch_count), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the post-edge PC and count, clock once, then retire the scoreboard.
    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        exp_t e;
        exp_q.push_back('{tag, pc, cnt});
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".pc"}, fetch_pc, e.pc);
            chk({e.tag, ".cnt"}, fetch_count, e.cnt);
        end
    endtask

    initial begin
        rst = 1; stall = 0; redirect_valid = 0; trap_valid = 0; halt_req = 0; resume = 0;
        fetch_ready = 1; redirect_pc = '0; trap_pc = '0;
        #1;
        step("reset", 32'h0, 0);
        chk("reset.valid", {31'b0, fetch_valid}, 0);
        chk("reset.misalign", {31'b0, misalign}, 0);
        chk("reset.mispc", misalign_pc, 0);
        chk("reset.halted", {31'b0, halted}, 0);
        rst = 0;
        step("boot", 32'h0, 0);
        chk("run.valid", {31'b0, fetch_valid}, 1);
        step("seq4", 32'h4, 1);
        step("seq8", 32'h8, 2);
        step("seqC", 32'hC, 3);
        step("seq10", 32'h10, 4);
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step("hold", 32'h10, 4);
            chk("hold.valid", {31'b0, fetch_valid}, 1);
        end
        fetch_ready = 1;
        step("release", 32'h14, 5);
        trap_valid = 1; trap_pc = 32'h103; redirect_valid = 1; redirect_pc = 32'h200;
        step("trap", 32'h100, 6);
        chk("trap.misalign", {31'b0, misalign}, 0);
        trap_valid = 0; redirect_pc = 32'h40;
        step("redir40", 32'h40, 7);
        stall = 1; redirect_pc = 32'h206;
        step("misredir", 32'h40, 7);
        chk("mis.pulse", {31'b0, misalign}, 1);
        chk("mis.pc", misalign_pc, 32'h206);
        chk("stall.valid", {31'b0, fetch_valid}, 0);
        redirect_valid = 0;
        step("mis.after", 32'h40, 7);
        chk("mis.clear", {31'b0, misalign}, 0);
        stall = 0; redirect_valid = 1; redirect_pc = 32'h80;
        step("redir80", 32'h80, 8);
        redirect_valid = 0; halt_req = 1;
        step("halt", 32'h84, 9);
        chk("halt.halted", {31'b0, halted}, 1);
        chk("halt.valid", {31'b0, fetch_valid}, 0);
        resume = 1;
        step("halt.both", 32'h84, 9);
        chk("both.halted", {31'b0, halted}, 1);
        halt_req = 0;
        step("resume", 32'h84, 9);
        chk("resume.halted", {31'b0, halted}, 0);
        chk("resume.valid", {31'b0, fetch_valid}, 1);
        resume = 0;
        step("resume.adv", 32'h88, 10);
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        step("top", 32'hFFFF_FFFC, 11);
        chk("top.plus", pc_plus_step, 32'h0);
        redirect_valid = 0;
        step("wrap", 32'h0, 12);
        step("post.wrap", 32'h4, 13);
        stall = 1;
        step("stall", 32'h4, 13);
        rst = 1;
        step("midrst", 32'h0, 0);
        chk("midrst.valid", {31'b0, fetch_valid}, 0);
        chk("midrst.halted", {31'b0, halted}, 0);
        rst = 0; stall = 0;
        step("reboot", 32'h0, 0);
        step("rerun", 32'h4, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
